// File: rtl/control_mag.sv
// Microwave magnetron control.
// Samples the front-panel requests, the door switch and the cook timer on
// every rising clock edge and produces registered set/reset requests for the
// external magnetron latch, together with an internal two-state on/off
// tracker. Stop always beats start.
// Inputs are assumed to be synchronous to clk already, so there is no
// debounce and no synchroniser stage.
module control_mag (
  input  logic clk,
  input  logic rst,
  input  logic startn,
  input  logic stopn,
  input  logic clearn,
  input  logic door_closed,
  input  logic timer_done,
  output logic set,
  output logic reset,
  output logic mag_on
);

  typedef enum logic [0:0] {StOff, StOn} state_e;

  state_e state_q, state_d;
  logic   set_q, set_d;
  logic   reset_q, reset_d;
  logic   stop_c;
  logic   start_c;

  // Request decode. Any stop-type event (door open, stop, clear, timer
  // expiry) wins over a start press.
  always_comb begin
    stop_c  = ~door_closed | ~stopn | ~clearn | timer_done;
    start_c = ~startn & door_closed & ~timer_done;
  end

  // Next-state logic for the latch requests and the on/off tracker.
  always_comb begin
    set_d   = start_c & ~stop_c;
    reset_d = stop_c;
    state_d = state_q;
    unique case (state_q)
      StOff:   if (start_c && !stop_c) state_d = StOn;
      StOn:    if (stop_c)             state_d = StOff;
      default: state_d = StOff;
    endcase
  end

  // All state is registered on the same edge, so mag_on rises in the same
  // cycle that set first appears. Reset is synchronous and ignores inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StOff;
      set_q   <= 1'b0;
      reset_q <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      reset_q <= reset_d;
    end
  end

  // Outputs come straight from flops; there is no input-to-output path.
  always_comb begin
    set    = set_q;
    reset  = reset_q;
    mag_on = (state_q == StOn);
  end

endmodule

// File: tb/tb_control_mag.sv
// Scoreboard bench for control_mag: a driver applies stimulus on the falling
// edge and queues the response expected after the next rising edge; a monitor
// pops and compares just after each rising edge.
module tb_control_mag;

  logic clk = 1'b0;
  logic rst, startn, stopn, clearn, door_closed, timer_done;
  logic set, reset, mag_on;

  typedef struct packed {
    logic set;
    logic reset;
    logic mag_on;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // Reference model state: what the DUT outputs should currently show.
  logic  m_known = 1'b0;
  resp_t m_cur;

  control_mag dut (
    .clk         (clk),
    .rst         (rst),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .set         (set),
    .reset       (reset),
    .mag_on      (mag_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Apply one cycle of inputs; queue the expected post-edge response.
  task automatic apply(input logic r, input logic s_n, input logic p_n, input logic c_n,
                       input logic door, input logic tmr);
    resp_t nxt;
    logic  stop, start;
    @(negedge clk);
    rst = r; startn = s_n; stopn = p_n; clearn = c_n; door_closed = door; timer_done = tmr;
    if (r) begin
      nxt = '0;
    end else begin
      stop  = !door || !p_n || !c_n || tmr;
      start = !s_n && door && !tmr;
      nxt.set    = start && !stop;
      nxt.reset  = stop;
      nxt.mag_on = stop ? 1'b0 : (start ? 1'b1 : m_cur.mag_on);
    end
    exp_q.push_back(nxt);
    // Input changes between edges must not disturb the registered outputs.
    #1;
    if (m_known) begin
      check("hold_set", set, m_cur.set);
      check("hold_reset", reset, m_cur.reset);
      check("hold_mag_on", mag_on, m_cur.mag_on);
    end
    m_cur   = nxt;
    m_known = 1'b1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  // Monitor: every cycle is an output cycle for this block.
  initial begin
    resp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("set", set, e.set);
        check("reset", reset, e.reset);
        check("mag_on", mag_on, e.mag_on);
        n_cmp++;
        if (set && reset) begin
          n_err++;
          $display("FAIL set_reset_exclusive: set=%b reset=%b, required not both 1", set, reset);
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; startn = 1'b1; stopn = 1'b1; clearn = 1'b1;
    door_closed = 1'b1; timer_done = 1'b0;

    // Reset, then directed scenarios.
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // inputs ignored during reset
    apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);  // door open
    idle();
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // start
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // start held, set stays high
    idle();                                     // mag_on holds 1
    idle();
    apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);  // start while stopping
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);  // timer expiry while on
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);  // clear
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // everything pressed, door open
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // sync reset while on
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);  // first post-reset edge is live
    apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);  // door open while on and start held

    // Randomised traffic biased toward idle so mag_on spends time in both states.
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(99) < 3),
            !($urandom_range(99) < 40),
            !($urandom_range(99) < 12),
            !($urandom_range(99) < 8),
            !($urandom_range(99) < 10),
            ($urandom_range(99) < 10));
    end
    idle();

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
